// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared LSU encodings (access sizes, FSM states) and the
//             alignment/legality helper used by the alignment datapath.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  // Access size codes, shared with the decoder tables
  localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSU_SIZE_WORD = 2'd2;

  // Transaction FSM states
  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_BUSY = 2'd1,
    LSU_ST_DONE = 2'd2
  } lsu_state_e;

  // True when the access may not go to the bus: unaligned half/word, or size 3
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      LSU_SIZE_BYTE: bad = 1'b0;
      LSU_SIZE_HALF: bad = addr_lo[0];
      LSU_SIZE_WORD: bad = |addr_lo;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Word-addressed request/acknowledge data-memory bus.
//             master = LSU side, slave = memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic: byte enables, store-data lane
//             replication, load extraction/extension and legality flag.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign_ext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] shifted;

  // Lane selection for both directions; size 3 falls into the word arm but is
  // flagged illegal, so its lanes are never used
  always_comb begin
    shifted      = i_rdata >> {i_addr_lo, 3'b000};
    o_misaligned = lsu_misaligned(i_size, i_addr_lo);
    case (i_size)
      LSU_SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign_ext & shifted[7]}}, shifted[7:0]};
      end
      LSU_SIZE_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = shifted;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit. Runs one request/ack bus transaction per memory
//             instruction, stalls the core until it completes, formats load
//             data and faults misaligned/illegal accesses or bus timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign_ext,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_stall,
  output logic [31:0]           o_rdata,
  output logic                  o_fault,
  lsu_if.master                 mem
);

  // The counter holds the number of BUSY cycles already spent without ack, so
  // the TIMEOUT-th BUSY cycle is the one where it equals TIMEOUT-1.
  localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  lsu_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            lo_q, lo_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  idle;
  logic [1:0]            al_size;
  logic [1:0]            al_lo;
  logic                  al_sign;
  logic [3:0]            al_be;
  logic [31:0]           al_wdata;
  logic [31:0]           al_rdata;
  logic                  al_misaligned;

  // In IDLE the aligner sees the live request; in BUSY it formats read data
  // with the captured size/offset/sign
  always_comb begin
    idle    = (state_q == LSU_ST_IDLE);
    al_size = idle ? i_size      : size_q;
    al_lo   = idle ? i_addr[1:0] : lo_q;
    al_sign = idle ? i_sign_ext  : sign_q;
  end

  lsu_align u_align (
    .i_size       (al_size),
    .i_addr_lo    (al_lo),
    .i_sign_ext   (al_sign),
    .i_wdata      (i_wdata),
    .i_rdata      (mem.mem_rdata),
    .o_be         (al_be),
    .o_wdata      (al_wdata),
    .o_rdata      (al_rdata),
    .o_misaligned (al_misaligned)
  );

  // Next-state and next-register computation for the transaction FSM
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (i_req && !al_misaligned) begin
          addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          we_d    = i_we;
          lo_d    = i_addr[1:0];
          size_d  = i_size;
          sign_d  = i_sign_ext;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = LSU_ST_BUSY;
        end
      end
      LSU_ST_BUSY: begin
        // Ack has priority over a timeout expiring in the same cycle
        if (mem.mem_ack) begin
          if (!we_q) rdata_d = al_rdata;
          req_d   = 1'b0;
          state_d = LSU_ST_DONE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = LSU_ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_ST_DONE: state_d = LSU_ST_IDLE;
      default:     state_d = LSU_ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears the bus request immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LSU_ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall covers the request cycle and all of BUSY; misalignment faults
  // combinationally in the request cycle, timeouts arrive registered
  always_comb begin
    o_stall = !i_rst && ((idle && i_req && !al_misaligned) ||
                         (state_q == LSU_ST_BUSY));
    o_fault = fault_q || (!i_rst && idle && i_req && al_misaligned);
  end

  assign o_rdata       = rdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu (TIMEOUT = 4): directed accesses,
//             a per-cycle reference model and literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'd0;
  logic        i_sign_ext = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_fault;

  lsu_if #(.ADDR_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_size     (i_size),
    .i_sign_ext (i_sign_ext),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_stall    (o_stall),
    .o_rdata    (o_rdata),
    .o_fault    (o_fault),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle expectations, set by the stimulus just after each rising edge
  logic        chk_en    = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_fault = 1'b0;
  logic        exp_req   = 1'b0;
  logic        exp_zero  = 1'b1;
  logic [31:0] exp_addr  = '0;
  logic [3:0]  exp_be    = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_we    = 1'b0;
  logic [31:0] m_rdata   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (arithmetic form of the access rules)
  function automatic logic m_legal(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (addr % 2) == 0;
      2'd2:    return (addr % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int lo;
    lo = int'(addr % 4);
    case (size)
      2'd0:    return 4'(1 << lo);
      2'd1:    return (lo < 2) ? 4'd3 : 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
      2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                         input logic sgn, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (size)
      2'd0: begin
        v = v & 32'hFF;
        if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = v & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- compare process, mid-cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, o_stall}, {31'b0, exp_stall});
      chk("fault", {31'b0, o_fault}, {31'b0, exp_fault});
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
      chk("rdata", o_rdata, m_rdata);
      if (exp_req) begin
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_be", {28'b0, bus.mem_be}, {28'b0, exp_be});
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we});
      end
      if (exp_zero) begin
        chk("zero_addr", bus.mem_addr, 32'h0);
        chk("zero_be", {28'b0, bus.mem_be}, 32'h0);
        chk("zero_wdata", bus.mem_wdata, 32'h0);
        chk("zero_we", {31'b0, bus.mem_we}, 32'h0);
      end
    end
  end

  // One memory instruction; ack_cycle = BUSY cycle carrying ack (0 = never)
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_cycle,
                           output int stalls, output logic faulted,
                           output logic [31:0] s_addr, output logic [31:0] s_be,
                           output logic [31:0] s_wdata);
    logic done, timed_out;
    stalls = 0; faulted = 1'b0; s_addr = '0; s_be = '0; s_wdata = '0;
    @(posedge clk); #1;
    exp_zero = 1'b0;
    i_req = 1'b1; i_we = we; i_size = size; i_sign_ext = sgn;
    i_addr = addr; i_wdata = wd; bus.mem_ack = 1'b0; bus.mem_rdata = rword;
    if (!m_legal(size, addr)) begin
      exp_stall = 1'b0; exp_fault = 1'b1; exp_req = 1'b0;
      #3; faulted = o_fault; if (o_stall) stalls++;
      @(posedge clk); #1;
      i_req = 1'b0; exp_fault = 1'b0;
      return;
    end
    exp_stall = 1'b1; exp_fault = 1'b0; exp_req = 1'b0;
    #3; if (o_stall) stalls++;
    done = 1'b0; timed_out = 1'b0;
    for (int k = 1; k <= TO && !done; k++) begin
      @(posedge clk); #1;
      bus.mem_ack = (k == ack_cycle);
      exp_req = 1'b1; exp_stall = 1'b1;
      exp_addr = addr & ~32'd3; exp_be = m_be(size, addr);
      exp_wdata = m_wdata(size, wd); exp_we = we;
      #3;
      if (o_stall) stalls++;
      s_addr = bus.mem_addr; s_be = {28'b0, bus.mem_be}; s_wdata = bus.mem_wdata;
      if (k == ack_cycle) done = 1'b1;
      else if (k == TO) begin done = 1'b1; timed_out = 1'b1; end
    end
    @(posedge clk); #1;
    i_req = 1'b0; bus.mem_ack = 1'b0;
    if (!timed_out && !we) m_rdata = m_load(size, addr, sgn, rword);
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = timed_out;
    #3; if (o_stall) stalls++; faulted = o_fault;
    @(posedge clk); #1;
    exp_fault = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          st;
  logic        flt;
  logic [31:0] sa, sb, sw;

  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
    rst = 1'b0;

    // Word load, ack in first BUSY cycle
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, st, flt, sa, sb, sw);
    chk("t1_stalls", st, 32'd2);
    chk("t1_addr", sa, 32'h100);
    chk("t1_be", sb, 32'hF);
    chk("t1_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("t1_fault", {31'b0, flt}, 32'h0);

    // Signed and unsigned byte load from lane 3
    do_access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80FF_FFFF, 1, st, flt, sa, sb, sw);
    chk("t2_be", sb, 32'h8);
    chk("t2_rdata", o_rdata, 32'hFFFF_FF80);
    do_access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80FF_FFFF, 1, st, flt, sa, sb, sw);
    chk("t3_rdata", o_rdata, 32'h0000_0080);

    // Half store, upper half, one wait cycle
    do_access(1'b1, 2'd1, 1'b0, 32'h42, 32'h1234_ABCD, 32'h0, 2, st, flt, sa, sb, sw);
    chk("t4_addr", sa, 32'h40);
    chk("t4_be", sb, 32'hC);
    chk("t4_wdata", sw, 32'hABCD_ABCD);
    chk("t4_stalls", st, 32'd3);
    chk("t4_rdata_kept", o_rdata, 32'h0000_0080);

    // Signed half load, upper half, two wait cycles
    do_access(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 32'h8001_1234, 3, st, flt, sa, sb, sw);
    chk("t5_rdata", o_rdata, 32'hFFFF_8001);
    chk("t5_stalls", st, 32'd4);

    // Byte store lane 1, unsigned half load lane 0
    do_access(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_0055, 32'h0, 1, st, flt, sa, sb, sw);
    chk("t6_wdata", sw, 32'h5555_5555);
    chk("t6_be", sb, 32'h2);
    do_access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h1234_F00D, 1, st, flt, sa, sb, sw);
    chk("t7_rdata", o_rdata, 32'h0000_F00D);

    // Misaligned and illegal accesses
    do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1, st, flt, sa, sb, sw);
    chk("t8_fault", {31'b0, flt}, 32'h1);
    chk("t8_stalls", st, 32'd0);
    do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1, st, flt, sa, sb, sw);
    chk("t8_size3_fault", {31'b0, flt}, 32'h1);
    do_access(1'b1, 2'd1, 1'b0, 32'h43, 32'h0, 32'h0, 1, st, flt, sa, sb, sw);
    chk("t8_half_fault", {31'b0, flt}, 32'h1);

    // Timeout with ack withheld, then ack on the last allowed cycle
    do_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1111_1111, 0, st, flt, sa, sb, sw);
    chk("t9_fault", {31'b0, flt}, 32'h1);
    chk("t9_stalls", st, 32'd5);
    chk("t9_rdata_kept", o_rdata, 32'h0000_F00D);
    do_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h2222_2222, 4, st, flt, sa, sb, sw);
    chk("t10_fault", {31'b0, flt}, 32'h0);
    chk("t10_stalls", st, 32'd5);
    chk("t10_rdata", o_rdata, 32'h2222_2222);

    // Reset pulsed in the 2nd BUSY cycle, then a late ack
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_sign_ext = 1'b0;
    i_addr = 32'h400; i_wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'hCAFE_F00D;
    exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_addr = 32'h400; exp_be = 4'hF; exp_wdata = 32'h0; exp_we = 1'b0;
    @(posedge clk); #1;
    chk("t11_req_before", {31'b0, bus.mem_req}, 32'h1);
    #1 rst = 1'b1;
    m_rdata = 32'h0; exp_req = 1'b0; exp_stall = 1'b0; exp_zero = 1'b1;
    #1 chk("t11_req_async", {31'b0, bus.mem_req}, 32'h0);
    chk("t11_stall_rst", {31'b0, o_stall}, 32'h0);
    chk("t11_rdata_rst", o_rdata, 32'h0);
    @(posedge clk); #1;
    i_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("t11_late_ack", o_rdata, 32'h0);

    // Recovery: word store after reset
    do_access(1'b1, 2'd2, 1'b0, 32'h8, 32'hA5A5_A5A5, 32'h0, 1, st, flt, sa, sb, sw);
    chk("t12_wdata", sw, 32'hA5A5_A5A5);
    chk("t12_addr", sa, 32'h8);
    chk("t12_fault", {31'b0, flt}, 32'h0);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit of the single-cycle RV32 core. It consumes the decoder's LSU controls (size, sign-extend, write-enable), the ALU-computed address and the rs2 store data. It runs one word-addressed request/acknowledge transaction on the data-memory bus and stalls the core until the access completes. It returns aligned, extended load data to the writeback mux and flags misaligned or illegal accesses without touching memory.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width presented by the core.
- `TIMEOUT`, default 0: cycles to wait for `i_mem_ack` before faulting; 0 disables the timeout.

Ports:
- `i_clk`  in  1  clock; all state on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  current instruction is a memory access; held with its operands stable while `o_stall`=1.
- `i_we`  in  1  1=store, 0=load (decoder `o_lsu_we`).
- `i_size`  in  2  0=byte, 1=half, 2=word, 3=illegal (decoder `o_lsu_size`).
- `i_sign_ext`  in  1  sign-extend load result (decoder `o_lsu_sign_ext`).
- `i_addr`  in  ADDR_WIDTH  byte address from the ALU.
- `i_wdata`  in  32  store data (rs2).
- `o_stall`  out  1  freeze PC and register file this cycle.
- `o_rdata`  out  32  formatted load data; valid in DONE.
- `o_fault`  out  1  one-cycle pulse: misaligned, illegal size, or timeout.
- `o_mem_req`  out  1  bus request; held until acknowledged.
- `o_mem_we`  out  1  bus write.
- `o_mem_addr`  out  ADDR_WIDTH  word address, bits [1:0] = 0.
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `i_mem_ack`  in  1  transaction complete; `i_mem_rdata` valid in the same cycle.
- `i_mem_rdata`  in  32  read word.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE with `i_req`=0: no action.
- IDLE with `i_req`=1 and a legal, aligned access:
  - Register the word address, BE, replicated wdata, `i_we`, `i_addr[1:0]`, size and sign.
  - Go to BUSY. `o_stall`=1 combinationally during this cycle.
- Alignment rules: half requires `addr[0]`=0; word requires `addr[1:0]`=0; size 3 is always illegal.
- IDLE with `i_req`=1 and a misaligned or illegal access:
  - `o_fault`=1 for that cycle, `o_stall`=0, no bus activity, stay in IDLE.
- BUSY:
  - `o_mem_req`=1 and `o_stall`=1.
  - On `i_mem_ack`: capture formatted read data (loads only; stores leave `o_rdata` unchanged), drop `o_mem_req` on the next edge, go to DONE.
- DONE: `o_stall`=0 for exactly one cycle, during which the core retires the instruction. Next state is IDLE.
- Byte enables:
  - byte: `1<<addr[1:0]`.
  - half: `4'b0011` when `addr[1]`=0, `4'b1100` when `addr[1]`=1.
  - word: `4'b1111`.
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load data: shift `i_mem_rdata` right by `8*addr[1:0]`, take 8, 16 or 32 bits, then sign- or zero-extend to 32.
- Timeout (only when `TIMEOUT`>0):
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches `TIMEOUT` with no ack: pulse `o_fault`, drop `o_mem_req`, go to DONE. `o_rdata` keeps its previous value.
  - If ack arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins and there is no fault.

## Timing
- Reset values: state IDLE; `o_mem_req`, `o_mem_we`, `o_mem_addr`, `o_mem_be`, `o_mem_wdata`, `o_rdata`, `o_fault`, counter all 0; `o_stall`=0 while `i_rst`=1.
- Reset asserted during BUSY drops `o_mem_req` immediately (asynchronously). A late ack is ignored in IDLE.
- `o_mem_req`/`o_mem_addr`/`o_mem_be`/`o_mem_wdata`/`o_mem_we` are registered and stable for the whole of BUSY.
- Ack in the first BUSY cycle gives minimum latency: request cycle (IDLE, stalled), BUSY cycle with ack (stalled), DONE. That is 2 stall cycles and 3 cycles per memory instruction. Each extra wait cycle adds one stall cycle.
- `i_mem_ack` outside BUSY is ignored.
- `o_fault` for a misalignment is combinational with `i_req`. The timeout fault is registered.

## Structure
- Shared header `lsu.vh` holds:
  - `LSU_SIZE_BYTE/HALF/WORD` (0/1/2), used by the decoder tables as well.
  - `LSU_ST_IDLE/BUSY/DONE` state encodings.
- Sub-module `lsu_align` (combinational): takes size, `addr[1:0]`, sign, store data and read word. It produces BE, replicated wdata, extracted/extended load data and the misaligned flag.

## Test plan
- Word load, addr `0x100`, ack in the first BUSY cycle: bus addr `0x100`, BE `1111`; `o_rdata`=`0xDEADBEEF` in DONE; `o_stall` high for exactly 2 cycles.
- Signed byte load, addr `0x203`, rdata `0x80FFFFFF`: BE `1000`; `o_rdata`=`0xFFFFFF80`. The same access unsigned gives `0x00000080`.
- Half store, addr `0x42`, wdata `0x1234ABCD`: `o_mem_addr`=`0x40`, BE `1100`, `o_mem_wdata`=`0xABCDABCD`, `o_mem_we`=1.
- Word load, addr `0x101`: `o_fault` pulses, `o_stall`=0, `o_mem_req` never asserts. Repeat with size 3 for the same result.
- `TIMEOUT`=4 with ack withheld: `o_fault` pulses after 4 BUSY cycles and the state returns through DONE to IDLE. A second run with ack on cycle 4 completes without a fault.
- `i_rst` pulsed on the 2nd BUSY cycle: `o_mem_req` falls in the same cycle and all outputs read 0. A later ack is ignored.
